// File: rtl/serdes_pkg.sv
// serdes_pkg
// Shared definitions for the serial framing blocks (deserializer and the
// matching serializer): frame FSM states, bit-order constants and the
// bit-counter width helper.
// No ports.

package serdes_pkg;

  // Frame FSM states shared by serializer and deserializer.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bit-order selector values for the MSB_FIRST parameter.
  localparam int SER_MSB_FIRST = 1;
  localparam int SER_LSB_FIRST = 0;

  // Counter wide enough to hold WIDTH+1 (a data frame plus parity bit).
  function automatic int counterWidth(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/serdes_out_buf.sv
// serdes_out_buf
// One-entry valid/ready holding register for completed words. A new word is
// taken when the entry is empty or is being drained in the same cycle;
// otherwise it is dropped and the sticky overrun flag is raised.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   i_load         a completed word is offered this cycle
//   i_data/i_perr  offered word and its parity-error flag
//   i_rdy          consumer ready
//   i_overrunClr   synchronous clear of the overrun flag
//   o_data/o_perr  buffered word and parity-error flag
//   o_vld          buffered word valid
//   o_overrun      sticky drop indication

module serdes_out_buf
  import serdes_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_perr,
  input  logic             i_rdy,
  input  logic             i_overrunClr,
  output logic [WIDTH-1:0] o_data,
  output logic             o_perr,
  output logic             o_vld,
  output logic             o_overrun
);

  logic [WIDTH-1:0] r_data;
  logic             r_perr;
  logic             r_vld;
  logic             r_overrun;

  logic w_accept;
  logic w_take;
  logic w_drop;

  assign w_accept = r_vld & i_rdy;
  // Draining and refilling in the same cycle gives zero-bubble back-to-back words.
  assign w_take   = i_load & (~r_vld | i_rdy);
  assign w_drop   = i_load & r_vld & ~i_rdy;

  // Data is only written on a take so it stays stable (and not zeroed) after a drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data    <= '0;
      r_perr    <= 1'b0;
      r_vld     <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_take) begin
        r_data <= i_data;
        r_perr <= i_perr;
        r_vld  <= 1'b1;
      end else if (w_accept) begin
        r_vld  <= 1'b0;
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (i_overrunClr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign o_data    = r_data;
  assign o_perr    = r_perr;
  assign o_vld     = r_vld;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/serial_frame_deserializer.sv
// serial_frame_deserializer
// Collects a strobed serial bit stream, framed by a start-of-frame marker,
// into one WIDTH-bit word and presents it through a one-entry valid/ready
// buffer (serdes_out_buf).
// Build option: define SERIAL_FRAME_DESERIALIZER_PARITY_EN to expect one
// trailing even-parity bit per frame and report mismatches on dout_perr;
// without it dout_perr is constant 0.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   si, si_vld        serial bit and its strobe
//   si_sof            marks the strobed bit as frame bit 0
//   dout, dout_vld    received word and valid
//   dout_rdy          consumer ready
//   dout_perr         parity error for the presented word
//   overrun           sticky flag: a completed word was dropped
//   overrun_clr       synchronous clear of overrun

module serial_frame_deserializer
  import serdes_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = SER_MSB_FIRST
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             si,
  input  logic             si_vld,
  input  logic             si_sof,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic             dout_rdy,
  output logic             dout_perr,
  output logic             overrun,
  input  logic             overrun_clr
);

`ifdef SERIAL_FRAME_DESERIALIZER_PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif
  localparam int CNT_W = counterWidth(WIDTH);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [FLEN-1:0]   r_shift;

  logic [FLEN-1:0]   w_nextShift;
  logic [WIDTH-1:0]  w_word;
  logic              w_perr;
  logic              w_lastBit;
  logic              w_complete;

  // The shift register spans the whole frame, so after FLEN bits it holds
  // exactly the frame; with parity the parity bit sits at the newest end.
  always_comb begin
    w_nextShift = r_shift;
    w_word      = '0;
    if (MSB_FIRST == SER_MSB_FIRST) begin
      w_nextShift = {r_shift[FLEN-2:0], si};
      w_word      = w_nextShift[FLEN-1 -: WIDTH];
    end else begin
      w_nextShift = {si, r_shift[FLEN-1:1]};
      w_word      = w_nextShift[WIDTH-1:0];
    end
  end

`ifdef SERIAL_FRAME_DESERIALIZER_PARITY_EN
  assign w_perr = ^w_nextShift;
`else
  assign w_perr = 1'b0;
`endif

  assign w_lastBit  = (r_cnt == CNT_W'(FLEN - 1));
  // A start-of-frame bit always restarts the frame, so it can never complete one.
  assign w_complete = si_vld & ~si_sof & (r_state == SHIFT) & w_lastBit;

  // Frame FSM: SOF (from any state) restarts at count 1; the bit that
  // reaches FLEN completes the frame and returns to IDLE on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (si_vld) begin
      if (si_sof) begin
        r_shift <= w_nextShift;
        r_cnt   <= CNT_W'(1);
        r_state <= SHIFT;
      end else if (r_state == SHIFT) begin
        r_shift <= w_nextShift;
        if (w_lastBit) begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end else begin
          r_cnt   <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  serdes_out_buf #(
    .WIDTH (WIDTH)
  ) u_outBuf (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (w_complete),
    .i_data       (w_word),
    .i_perr       (w_perr),
    .i_rdy        (dout_rdy),
    .i_overrunClr (overrun_clr),
    .o_data       (dout),
    .o_perr       (dout_perr),
    .o_vld        (dout_vld),
    .o_overrun    (overrun)
  );

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// tb_serial_frame_deserializer
// Drives one serial stream into an MSB-first and an LSB-first instance
// (WIDTH=8) and checks both against a frame-level reference model through a
// scoreboard queue of expected words.
// Build option: SERIAL_FRAME_DESERIALIZER_PARITY_EN adds a parity bit per frame.

module tb_serial_frame_deserializer;

  localparam int WIDTH = 8;
`ifdef SERIAL_FRAME_DESERIALIZER_PARITY_EN
  localparam int FLEN   = WIDTH + 1;
  localparam bit PARITY = 1'b1;
`else
  localparam int FLEN   = WIDTH;
  localparam bit PARITY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstN, siBit, siVld, siSof, doutRdy, overrunClr;
  logic [WIDTH-1:0] doutA, doutB;
  logic doutVldA, doutVldB, doutPerrA, doutPerrB, overrunA, overrunB;

  always #5 clk = ~clk;

  serial_frame_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(1)) dutMsb (
    .clk(clk), .rst_n(rstN), .si(siBit), .si_vld(siVld), .si_sof(siSof),
    .dout(doutA), .dout_vld(doutVldA), .dout_rdy(doutRdy),
    .dout_perr(doutPerrA), .overrun(overrunA), .overrun_clr(overrunClr)
  );

  serial_frame_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(0)) dutLsb (
    .clk(clk), .rst_n(rstN), .si(siBit), .si_vld(siVld), .si_sof(siSof),
    .dout(doutB), .dout_vld(doutVldB), .dout_rdy(doutRdy),
    .dout_perr(doutPerrB), .overrun(overrunB), .overrun_clr(overrunClr)
  );

  typedef struct {
    logic [WIDTH-1:0] wordMsb;
    logic [WIDTH-1:0] wordLsb;
    logic             perr;
  } exp_t;

  exp_t expQ[$];
  bit   frameBits[$];
  bit   inFrame   = 1'b0;
  bit   occ       = 1'b0;
  bit   modelOvr  = 1'b0;
  bit   monitorOn = 1'b0;
  int   errors    = 0;
  int   checks    = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model at frame level: collect strobed bits into a list, turn a
  // full list into a word by bit position, and track buffer occupancy/overrun.
  always @(posedge clk) begin : model
    exp_t e;
    bit   complete;
    bit   accepted;
    if (!rstN) begin
      frameBits.delete();
      expQ.delete();
      inFrame  = 1'b0;
      occ      = 1'b0;
      modelOvr = 1'b0;
    end else begin
      complete = 1'b0;
      accepted = occ && doutRdy;
      if (siVld) begin
        if (siSof) begin
          frameBits.delete();
          frameBits.push_back(siBit);
          inFrame = 1'b1;
        end else if (inFrame) begin
          frameBits.push_back(siBit);
        end
        if (inFrame && frameBits.size() == FLEN) begin
          e.wordMsb = '0;
          e.wordLsb = '0;
          e.perr    = 1'b0;
          for (int i = 0; i < WIDTH; i++) begin
            e.wordMsb[WIDTH-1-i] = frameBits[i];
            e.wordLsb[i]         = frameBits[i];
          end
          if (PARITY) begin
            for (int i = 0; i < FLEN; i++) e.perr = e.perr ^ frameBits[i];
          end
          complete = 1'b1;
          inFrame  = 1'b0;
          frameBits.delete();
        end
      end
      if (accepted) occ = 1'b0;
      if (complete && !occ) begin
        expQ.push_back(e);
        occ = 1'b1;
      end else if (complete) begin
        modelOvr = 1'b1;
      end else if (overrunClr) begin
        modelOvr = 1'b0;
      end
    end
  end

  // Monitor: compares presented words against the scoreboard head and pops on handshake.
  always @(negedge clk) begin
    if (monitorOn) begin
      checkOutput("vldMsb", 32'(doutVldA), 32'(occ));
      checkOutput("vldLsb", 32'(doutVldB), 32'(occ));
      checkOutput("ovrMsb", 32'(overrunA), 32'(modelOvr));
      checkOutput("ovrLsb", 32'(overrunB), 32'(modelOvr));
      if (doutVldA) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedWord: actual=%0h required=none", doutA);
        end else begin
          checkOutput("doutMsb", 32'(doutA), 32'(expQ[0].wordMsb));
          checkOutput("doutLsb", 32'(doutB), 32'(expQ[0].wordLsb));
          checkOutput("perrMsb", 32'(doutPerrA), 32'(expQ[0].perr));
          checkOutput("perrLsb", 32'(doutPerrB), 32'(expQ[0].perr));
          if (doutRdy) void'(expQ.pop_front());
        end
      end
    end
  end

  task automatic drive(input bit vld, input bit sof, input bit s, input bit rdy, input bit clr);
    siVld      = vld;
    siSof      = sof;
    siBit      = s;
    doutRdy    = rdy;
    overrunClr = clr;
    @(posedge clk);
    #2;
  endtask

  // Sends the first nBits of a frame carrying data in the chosen bit order;
  // rdyLast is the ready value on the frame's final bit.
  task automatic applyStimulus(input logic [WIDTH-1:0] data, input bit lsbOrder, input bit gapped,
                               input int nBits, input bit parityFlip, input bit rdy, input bit rdyLast);
    bit bits[FLEN];
    int n;
    for (int i = 0; i < WIDTH; i++) bits[i] = lsbOrder ? data[i] : data[WIDTH-1-i];
    if (PARITY) bits[FLEN-1] = (^data) ^ parityFlip;
    n = (nBits < FLEN) ? nBits : FLEN;
    for (int i = 0; i < n; i++) begin
      drive(1'b1, i == 0, bits[i], (i == FLEN - 1) ? rdyLast : rdy, 1'b0);
      if (gapped && i < n - 1) drive(1'b0, 1'b0, 1'($urandom), rdy, 1'b0);
    end
  endtask

  initial begin
    rstN = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    monitorOn = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rstDoutMsb", 32'(doutA), 32'h0);
    checkOutput("rstDoutLsb", 32'(doutB), 32'h0);
    checkOutput("rstPerr", 32'(doutPerrA), 32'h0);
    rstN = 1'b1;

    // Basic MSB-first frame, continuous strobe.
    applyStimulus(8'hA5, 1'b0, 1'b0, FLEN, 1'b0, 1'b1, 1'b1);
    checkOutput("basicVld", 32'(doutVldA), 32'h1);
    checkOutput("basicA5", 32'(doutA), 32'hA5);
    checkOutput("basicOvr", 32'(overrunA), 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Gapped strobe, LSB-first.
    applyStimulus(8'h3C, 1'b1, 1'b1, FLEN, 1'b0, 1'b1, 1'b1);
    checkOutput("gap3C", 32'(doutB), 32'h3C);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Resync: partial frame, then a fresh SOF.
    applyStimulus(8'hFF, 1'b0, 1'b0, 5, 1'b0, 1'b1, 1'b1);
    applyStimulus(8'h81, 1'b0, 1'b0, FLEN, 1'b0, 1'b1, 1'b1);
    checkOutput("resync81", 32'(doutA), 32'h81);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Backpressure and overrun.
    applyStimulus(8'h11, 1'b0, 1'b0, FLEN, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h22, 1'b0, 1'b0, FLEN, 1'b0, 1'b0, 1'b0);
    checkOutput("bpHold11", 32'(doutA), 32'h11);
    checkOutput("bpOverrun", 32'(overrunA), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("bpDrained", 32'(doutVldA), 32'h0);
    checkOutput("bpKeepData", 32'(doutA), 32'h11);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("bpOvrClr", 32'(overrunA), 32'h0);

    // Back-to-back: ready only on the second frame's completing bit.
    applyStimulus(8'h55, 1'b0, 1'b0, FLEN, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'hAA, 1'b0, 1'b0, FLEN, 1'b0, 1'b0, 1'b1);
    checkOutput("b2bAA", 32'(doutA), 32'hAA);
    checkOutput("b2bOvr", 32'(overrunA), 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset mid-frame with a word already buffered.
    applyStimulus(8'h77, 1'b0, 1'b0, FLEN, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'hF0, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0);
    rstN = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("midRstDout", 32'(doutA), 32'h0);
    checkOutput("midRstVld", 32'(doutVldA), 32'h0);
    rstN = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Parity: wrong parity bit, then correct parity bit.
    applyStimulus(8'hA5, 1'b0, 1'b0, FLEN, 1'b1, 1'b1, 1'b1);
    checkOutput("parBadData", 32'(doutA), 32'hA5);
    checkOutput("parBadPerr", 32'(doutPerrA), PARITY ? 32'h1 : 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'hA5, 1'b0, 1'b0, FLEN, 1'b0, 1'b1, 1'b1);
    checkOutput("parGoodPerr", 32'(doutPerrA), 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Random traffic with random resyncs, backpressure and clears.
    for (int i = 0; i < 600; i++) begin
      bit v;
      v = ($urandom % 4) != 0;
      drive(v, v && (($urandom % 10) == 0), 1'($urandom), ($urandom % 3) != 0,
            ($urandom % 16) == 0);
    end

    repeat (10) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("drainEmpty", 32'(expQ.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
